// File: rtl/matrix_tx_sequencer_pkg.sv
// Shared definitions for the result-matrix UART dump sequencer: state encoding,
// LED codes, default frame header and checksum width.
package matrix_tx_sequencer_pkg;

  localparam int         CSUM_W         = 8;
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  // Issue states load the transmitter; *_WAIT/SEND states wait for ack then free.
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_HDR_WAIT,
    S_READ,
    S_LOAD,
    S_SEND,
    S_FIN,
    S_FIN_WAIT
  } state_t;

  localparam logic [4:0] LED_IDLE   = 5'b10000;
  localparam logic [4:0] LED_HDR    = 5'b01000;
  localparam logic [4:0] LED_READ   = 5'b00100;
  localparam logic [4:0] LED_SEND   = 5'b00010;
  localparam logic [4:0] LED_FINISH = 5'b00001;

  function automatic logic [4:0] state_led_of(input state_t s);
    logic [4:0] led;
    led = LED_IDLE;
    case (s)
      S_IDLE:             led = LED_IDLE;
      S_HDR, S_HDR_WAIT:  led = LED_HDR;
      S_READ, S_LOAD:     led = LED_READ;
      S_SEND:             led = LED_SEND;
      S_FIN, S_FIN_WAIT:  led = LED_FINISH;
      default:            led = LED_IDLE;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/matrix_tx_sequencer_sync_edge.sv
// Two-flop synchronizer with rising-edge detect for an asynchronous level input.
// Latency: sync_out 2 slow_clk, rise 2 slow_clk after the input edge; no backpressure.
module matrix_tx_sequencer_sync_edge (
  input  logic slow_clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [2:0] shift;

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
    end else begin
      shift <= {shift[1:0], async_in};
    end
  end

  assign sync_out = shift[1];
  assign rise     = shift[1] & ~shift[2];

endmodule

// File: rtl/matrix_tx_sequencer.sv
// Dumps result matrix R as HEADER, row-major elements, 8-bit checksum to the UART transmitter.
// Latency: start edge to first tx_start is 2 slow_clk; each byte waits for tx ack then free, or aborts on timeout.
module matrix_tx_sequencer
  import matrix_tx_sequencer_pkg::*;
#(
  parameter int         ROWS        = 2,
  parameter int         COLS        = 2,
  parameter int         ADDR_W      = 6,
  parameter logic [7:0] HEADER      = DEFAULT_HEADER,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic              slow_clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [4:0]        state_led,
  output logic [ADDR_W:0]   sent_count
);

  localparam int              TMR_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [ADDR_W:0]  LAST_IDX = (ADDR_W + 1)'(ROWS * COLS - 1);

  state_t             state, state_n;
  logic               start_q;
  logic               start_rise;
  logic               busy_sync;
  logic               tx_ack;
  logic               tx_free;
  logic               acked;
  logic [TMR_W-1:0]   timer;
  logic [CSUM_W-1:0]  checksum;
  logic               wait_timeout;

  logic tx_start_n, ld_hdr, ld_elem, ld_csum, frame_clr;
  logic wait_step, cnt_inc, set_err, set_done;

  matrix_tx_sequencer_sync_edge u_busy_sync (
    .slow_clk (slow_clk),
    .rst      (rst),
    .async_in (tx_busy),
    .sync_out (busy_sync),
    .rise     (tx_ack)
  );

  assign tx_free      = ~busy_sync;
  assign start_rise   = start & ~start_q;
  assign wait_timeout = ~acked & ~tx_ack & (timer == TMR_LAST);

  always_comb begin
    state_n    = state;
    tx_start_n = 1'b0;
    ld_hdr     = 1'b0;
    ld_elem    = 1'b0;
    ld_csum    = 1'b0;
    frame_clr  = 1'b0;
    wait_step  = 1'b0;
    cnt_inc    = 1'b0;
    set_err    = 1'b0;
    set_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_rise) begin
          frame_clr = 1'b1;
          state_n   = S_HDR;
        end
      end
      S_HDR: begin
        if (tx_free) begin
          tx_start_n = 1'b1;
          ld_hdr     = 1'b1;
          state_n    = S_HDR_WAIT;
        end
      end
      S_HDR_WAIT: begin
        wait_step = 1'b1;
        if (acked && tx_free) begin
          state_n = S_READ;
        end else if (wait_timeout) begin
          set_err = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_READ: begin
        if (tx_free) begin
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_start_n = 1'b1;
        ld_elem    = 1'b1;
        state_n    = S_SEND;
      end
      S_SEND: begin
        wait_step = 1'b1;
        if (acked && tx_free) begin
          cnt_inc = 1'b1;
          state_n = (sent_count == LAST_IDX) ? S_FIN : S_READ;
        end else if (wait_timeout) begin
          set_err = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_FIN: begin
        if (tx_free) begin
          tx_start_n = 1'b1;
          ld_csum    = 1'b1;
          state_n    = S_FIN_WAIT;
        end
      end
      S_FIN_WAIT: begin
        wait_step = 1'b1;
        if (acked && tx_free) begin
          set_done = 1'b1;
          state_n  = S_IDLE;
        end else if (wait_timeout) begin
          set_err = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // start_q resets high so a start level held through reset release is not an edge.
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      start_q    <= 1'b1;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      sent_count <= '0;
      checksum   <= '0;
      timer      <= '0;
      acked      <= 1'b0;
    end else begin
      start_q  <= start;
      tx_start <= tx_start_n;
      done     <= set_done;
      if (frame_clr) begin
        busy       <= 1'b1;
        error      <= 1'b0;
        sent_count <= '0;
        checksum   <= '0;
      end
      if (ld_hdr) begin
        tx_data <= HEADER;
      end
      if (ld_elem) begin
        tx_data  <= mem_rd_data;
        checksum <= checksum + mem_rd_data;
      end
      if (ld_csum) begin
        tx_data <= checksum;
      end
      if (tx_start_n) begin
        timer <= '0;
        acked <= 1'b0;
      end else if (wait_step && !acked) begin
        if (tx_ack) begin
          acked <= 1'b1;
        end else begin
          timer <= timer + TMR_W'(1);
        end
      end
      if (cnt_inc) begin
        sent_count <= sent_count + (ADDR_W + 1)'(1);
      end
      if (set_err) begin
        error <= 1'b1;
        busy  <= 1'b0;
      end
      if (set_done) begin
        busy <= 1'b0;
      end
    end
  end

  assign mem_rd_en   = (state == S_READ) && tx_free;
  assign mem_rd_addr = (state == S_READ) ? sent_count[ADDR_W-1:0] : '0;
  assign state_led   = state_led_of(state);

endmodule

// File: tb/tb_matrix_tx_sequencer.sv
// Self-checking bench: byte-level transmitter/memory models, table vectors and random frames.
module tb_matrix_tx_sequencer;

  logic       slow_clk;
  logic       rst;
  logic       start;
  logic       mem_rd_en;
  logic [5:0] mem_rd_addr;
  logic [7:0] mem_rd_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       busy;
  logic       done;
  logic       error;
  logic [4:0] state_led;
  logic [6:0] sent_count;

  matrix_tx_sequencer dut (
    .slow_clk    (slow_clk),
    .rst         (rst),
    .start       (start),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .state_led   (state_led),
    .sent_count  (sent_count)
  );

  initial begin
    slow_clk = 1'b0;
    forever #5 slow_clk = ~slow_clk;
  end

  // Environment state: memory, transmitter behaviour knobs, observed bytes
  logic [7:0] mem [64];
  int         tx_len  = 10;
  int         mute_at = 0;
  logic       clr_req = 1'b0;
  logic [7:0] rx_q [$];
  int         pulses    = 0;
  int         done_cnt  = 0;
  int         viol      = 0;
  int         stab_err  = 0;
  int         busy_left = 0;
  int         mute_cyc  = 0;
  int         cyc       = 0;
  logic [7:0] last_byte = 8'h00;

  always @(posedge slow_clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  // Transmitter: each tx_start captures one byte and holds tx_busy for tx_len cycles
  always @(negedge slow_clk) begin
    if (clr_req) begin
      rx_q.delete();
      pulses   = 0;
      done_cnt = 0;
    end
    if (rst) begin
      busy_left = 0;
      tx_busy   = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          tx_busy = 1'b0;
          if (tx_data !== last_byte) stab_err++;
        end
      end
      if (tx_start) begin
        if (tx_busy) viol++;
        pulses++;
        rx_q.push_back(tx_data);
        last_byte = tx_data;
        if (pulses == mute_at) begin
          mute_cyc = cyc;
        end else begin
          tx_busy   = 1'b1;
          busy_left = tx_len;
        end
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge slow_clk);
    #1;
  endtask

  typedef struct {
    logic [3:0][7:0] m;
    int              len;
    int              mute;
    bit              toggle;
    bit              exp_err;
    logic [7:0]      exp_csum;
    int              exp_bytes;
    logic [6:0]      exp_sent;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, input int len, mute,
                              input bit tog, err, input logic [7:0] cs, input int nb,
                              input logic [6:0] sent);
    vec_t v;
    v.m[0] = b0; v.m[1] = b1; v.m[2] = b2; v.m[3] = b3;
    v.len = len; v.mute = mute; v.toggle = tog; v.exp_err = err;
    v.exp_csum = cs; v.exp_bytes = nb; v.exp_sent = sent;
    return v;
  endfunction

  int end_cyc = 0;

  task automatic run_frame(input bit toggle, input bit chk_lat, output bit timed_out);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    start = 1'b1;
    tick();
    if (chk_lat) begin
      check("lat_no_pulse_first_edge", {31'd0, tx_start}, 32'd0);
      check("busy_after_start", {31'd0, busy}, 32'd1);
      tick();
      check("lat_pulse_second_edge", {31'd0, tx_start}, 32'd1);
      check("first_byte_header", {24'd0, tx_data}, 32'hA5);
    end
    timed_out = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (toggle) start = ((i % 7) < 3);
      tick();
      if (!busy) begin
        timed_out = 1'b0;
        end_cyc   = cyc;
        break;
      end
    end
    start = 1'b0;
    repeat (5) tick();
  endtask

  task automatic compare_frame(input string tag, input logic [7:0] exp [6], input int nb,
                               input bit err, input logic [6:0] sent, input bit to);
    check({tag, "_timeout"}, {31'd0, to}, 32'd0);
    check({tag, "_nbytes"}, rx_q.size(), nb);
    for (int i = 0; i < nb && i < rx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp[i]});
    check({tag, "_done_cnt"}, done_cnt, err ? 0 : 1);
    check({tag, "_error"}, {31'd0, error}, {31'd0, err});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_sent_count"}, {25'd0, sent_count}, {25'd0, sent});
    check({tag, "_led_idle"}, {27'd0, state_led}, 32'h10);
  endtask

  vec_t       vecs [6];
  logic [7:0] exp [6];
  bit         to;
  int         sum;
  int         p_before;

  initial begin
    vecs[0] = mk(8'h03, 8'h00, 8'h07, 8'hFF, 10, 0, 0, 0, 8'h09, 6, 7'd4);
    vecs[1] = mk(8'h00, 8'h00, 8'h00, 8'h00,  4, 0, 0, 0, 8'h00, 6, 7'd4);
    vecs[2] = mk(8'h01, 8'h02, 8'h03, 8'h04,  3, 0, 1, 0, 8'h0A, 6, 7'd4);
    vecs[3] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 12, 0, 0, 0, 8'hFC, 6, 7'd4);
    vecs[4] = mk(8'h80, 8'h80, 8'h01, 8'h00,  6, 0, 1, 0, 8'h01, 6, 7'd4);
    vecs[5] = mk(8'h11, 8'h22, 8'h33, 8'h44, 10, 3, 0, 1, 8'h00, 3, 7'd1);
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    // Reset with start already high
    rst   = 1'b1;
    start = 1'b1;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_sent_count", {25'd0, sent_count}, 32'd0);
    check("rst_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst_led", {27'd0, state_led}, 32'h10);
    rst = 1'b0;
    repeat (20) tick();
    check("held_start_no_pulse", pulses, 0);
    check("held_start_not_busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    tick();

    // Table vectors
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) mem[i] = vecs[v].m[i];
      tx_len  = vecs[v].len;
      mute_at = vecs[v].mute;
      exp[0]  = 8'hA5;
      for (int i = 0; i < 4; i++) exp[i+1] = vecs[v].m[i];
      exp[5]  = vecs[v].exp_csum;
      run_frame(vecs[v].toggle, (v == 0), to);
      compare_frame($sformatf("vec%0d", v), exp, vecs[v].exp_bytes, vecs[v].exp_err,
                    vecs[v].exp_sent, to);
      if (vecs[v].exp_err) check("timeout_cycles", end_cyc - mute_cyc, 16);
      p_before = pulses;
      repeat (10) tick();
      check($sformatf("vec%0d_no_extra_frame", v), pulses, p_before);
    end
    mute_at = 0;

    // Reset during the second element, then a clean frame
    for (int i = 0; i < 4; i++) mem[i] = 8'h10 + 8'(i);
    tx_len  = 8;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 300 && pulses < 3; i++) tick();
    check("mid_rst_reached_elem2", {31'd0, (pulses >= 3)}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("mid_rst_sent_count", {25'd0, sent_count}, 32'd0);
    check("mid_rst_led", {27'd0, state_led}, 32'h10);
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    exp[0] = 8'hA5;
    for (int i = 0; i < 4; i++) exp[i+1] = mem[i];
    exp[5] = 8'h46;
    run_frame(1'b0, 1'b0, to);
    compare_frame("after_rst", exp, 6, 1'b0, 7'd4, to);

    // Random frames against the byte-level model
    for (int r = 0; r < 8; r++) begin
      sum = 0;
      exp[0] = 8'hA5;
      for (int i = 0; i < 4; i++) begin
        mem[i]   = 8'($urandom_range(0, 255));
        exp[i+1] = mem[i];
        sum      = sum + int'(mem[i]);
      end
      exp[5] = 8'(sum % 256);
      tx_len = $urandom_range(3, 12);
      run_frame(bit'($urandom_range(0, 1)), 1'b0, to);
      compare_frame($sformatf("rnd%0d", r), exp, 6, 1'b0, 7'd4, to);
    end

    check("no_pulse_while_tx_busy", viol, 0);
    check("tx_data_stable_during_busy", stab_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
